// File: rtl/direction_select_ctrl.sv
// Pushbutton conditioner: two-flop synchroniser, debounce FSM and a select
// bit that toggles once per accepted press.
module direction_select_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic clear,
   input  logic btn_raw,
   output logic select,
   output logic press_pulse,
   output logic btn_stable
);

   localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IdleLow,
      WaitHigh,
      IdleHigh,
      WaitLow
   } state_t;

   state_t               state, state_next;
   logic [CNT_WIDTH-1:0] cnt, cnt_next;
   logic                 sync_1, sync_2;
   logic                 select_next, press_pulse_next, btn_stable_next;

   always_ff @(posedge clk) begin
      if (clear) begin
         sync_1      <= 1'b0;
         sync_2      <= 1'b0;
         state       <= IdleLow;
         cnt         <= '0;
         select      <= 1'b0;
         press_pulse <= 1'b0;
         btn_stable  <= 1'b0;
      end else begin
         sync_1      <= btn_raw;
         sync_2      <= sync_1;
         state       <= state_next;
         cnt         <= cnt_next;
         select      <= select_next;
         press_pulse <= press_pulse_next;
         btn_stable  <= btn_stable_next;
      end
   end

   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      select_next      = select;
      press_pulse_next = 1'b0;
      btn_stable_next  = btn_stable;

      unique case (state)
         IdleLow: begin
            if (sync_2) begin
               state_next = WaitHigh;
               cnt_next   = CntOne;
            end else begin
               cnt_next = '0;
            end
         end
         WaitHigh: begin
            if (!sync_2) begin
               state_next = IdleLow;
               cnt_next   = '0;
            end else if (cnt == CntLast) begin
               state_next       = IdleHigh;
               cnt_next         = '0;
               btn_stable_next  = 1'b1;
               press_pulse_next = 1'b1;
               select_next      = ~select;
            end else begin
               cnt_next = cnt + CntOne;
            end
         end
         IdleHigh: begin
            if (!sync_2) begin
               state_next = WaitLow;
               cnt_next   = CntOne;
            end
         end
         WaitLow: begin
            // Release path: no pulse, no toggle.
            if (sync_2) begin
               state_next = IdleHigh;
               cnt_next   = '0;
            end else if (cnt == CntLast) begin
               state_next      = IdleLow;
               cnt_next        = '0;
               btn_stable_next = 1'b0;
            end else begin
               cnt_next = cnt + CntOne;
            end
         end
         default: begin
            state_next = IdleLow;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_direction_select_ctrl.sv
// Directed bench for direction_select_ctrl with DEBOUNCE_CYCLES = 4.
module tb_direction_select_ctrl;

   localparam int unsigned Deb = 4;

   logic clk = 1'b0;
   logic clear;
   logic btn_raw;
   logic select;
   logic press_pulse;
   logic btn_stable;

   int checks = 0;
   int errors = 0;
   int pulse_total = 0;
   int base;

   direction_select_ctrl #(
      .DEBOUNCE_CYCLES(Deb)
   ) dut (
      .clk        (clk),
      .clear      (clear),
      .btn_raw    (btn_raw),
      .select     (select),
      .press_pulse(press_pulse),
      .btn_stable (btn_stable)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (press_pulse) pulse_total++;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges; returns 1 time unit after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clear();
      btn_raw = 1'b0;
      clear   = 1'b1;
      tick(2);
      clear = 1'b0;
      tick(2);
   endtask

   initial begin
      clear   = 1'b0;
      btn_raw = 1'b0;
      #2;

      // Reset with the button held high.
      clear   = 1'b1;
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("rst_select", select, 0);
         check("rst_pulse", press_pulse, 0);
         check("rst_stable", btn_stable, 0);
      end
      clear = 1'b0;
      tick(1);
      check("post_rst_select", select, 0);
      check("post_rst_pulse", press_pulse, 0);
      check("post_rst_stable", btn_stable, 0);
      do_clear();

      // Clean press: first sampled at edge N, outputs change after edge N+Deb+1.
      base    = pulse_total;
      btn_raw = 1'b1;
      tick(Deb + 1);
      check("press_early_pulse", press_pulse, 0);
      check("press_early_select", select, 0);
      check("press_early_stable", btn_stable, 0);
      tick(1);
      check("press_pulse", press_pulse, 1);
      check("press_select", select, 1);
      check("press_stable", btn_stable, 1);
      tick(1);
      check("press_pulse_drop", press_pulse, 0);
      tick(20 - Deb - 3);
      check("press_one_pulse", pulse_total - base, 1);
      check("press_hold_select", select, 1);

      // Clean release: same latency, no pulse, no toggle.
      btn_raw = 1'b0;
      tick(Deb + 1);
      check("rel_early_stable", btn_stable, 1);
      tick(1);
      check("rel_stable", btn_stable, 0);
      check("rel_pulse", press_pulse, 0);
      tick(4);
      check("rel_no_pulse", pulse_total - base, 1);
      check("rel_select", select, 1);

      // Bounce on the press edge never reaches the threshold.
      do_clear();
      base = pulse_total;
      btn_raw = 1'b1; tick(3);
      btn_raw = 1'b0; tick(1);
      btn_raw = 1'b1; tick(3);
      btn_raw = 1'b0; tick(1);
      tick(10);
      check("bounce_pulses", pulse_total - base, 0);
      check("bounce_select", select, 0);
      check("bounce_stable", btn_stable, 0);

      // Two full press/release cycles.
      base = pulse_total;
      for (int k = 0; k < 2; k++) begin
         btn_raw = 1'b1; tick(10);
         check("cyc_hi_stable", btn_stable, 1);
         btn_raw = 1'b0; tick(10);
         check("cyc_lo_stable", btn_stable, 0);
         check("cyc_pulses", pulse_total - base, k + 1);
         check("cyc_select", select, (k == 0) ? 1 : 0);
      end

      // Release bounce after an accepted press.
      base = pulse_total;
      btn_raw = 1'b1; tick(10);
      check("rb_select_set", select, 1);
      for (int k = 0; k < 3; k++) begin
         btn_raw = 1'b0; tick(2);
         btn_raw = 1'b1; tick(2);
         check("rb_stable_mid", btn_stable, 1);
      end
      tick(8);
      check("rb_stable", btn_stable, 1);
      check("rb_pulses", pulse_total - base, 1);
      check("rb_select", select, 1);

      // Clear three edges into a press aborts it; a fresh debounce follows.
      do_clear();
      base    = pulse_total;
      btn_raw = 1'b1;
      tick(3);
      clear = 1'b1;
      tick(1);
      check("clr_select", select, 0);
      check("clr_pulse", press_pulse, 0);
      clear = 1'b0;
      tick(Deb + 1);
      check("clr_early_pulse", pulse_total - base, 0);
      tick(1);
      check("clr_pulse_late", press_pulse, 1);
      check("clr_select_late", select, 1);
      tick(3);
      check("clr_one_pulse", pulse_total - base, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule
